// File: rtl/dcache_bank_gather_pkg.sv
// Shared sizing and FSM encoding for the dcache bank gather block.
// Defaults describe a 4-bank, 4-lane, 32-bit word configuration.
package dcache_bank_gather_pkg;
    localparam int DCACHE_BLOCKWORDS = 4;
    localparam int DCACHE_NLANES     = 4;
    localparam int DCACHE_WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RSP   = 2'd3
    } state_e;
endpackage

// File: rtl/dcache_bank_gather_if.sv
// Request, bank-read and response signals of the bank gather block.
// The slave modport is the gather block; the master modport is the core/SRAM side.
interface dcache_bank_gather_if
    import dcache_bank_gather_pkg::*;
#(
    parameter int NBANK  = DCACHE_BLOCKWORDS,
    parameter int NLANE  = DCACHE_NLANES,
    parameter int WORD_W = DCACHE_WORD_W
) ();
    localparam int LB = $clog2(NBANK);
    localparam int LL = $clog2(NLANE);

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [NLANE-1:0]        req_lane_mask_i;
    logic [LB*NLANE-1:0]     req_block_idx_i;
    logic [NBANK-1:0]        bank_rd_en_o;
    logic [LL*NBANK-1:0]     bank_lane_idx_o;
    logic [WORD_W*NBANK-1:0] bank_rd_data_i;
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [WORD_W*NLANE-1:0] rsp_data_o;
    logic [NLANE-1:0]        rsp_mask_o;

    modport slave (
        input  req_valid_i, req_lane_mask_i, req_block_idx_i, bank_rd_data_i, rsp_ready_i,
        output req_ready_o, bank_rd_en_o, bank_lane_idx_o, rsp_valid_o, rsp_data_o, rsp_mask_o
    );

    modport master (
        output req_valid_i, req_lane_mask_i, req_block_idx_i, bank_rd_data_i, rsp_ready_i,
        input  req_ready_o, bank_rd_en_o, bank_lane_idx_o, rsp_valid_o, rsp_data_o, rsp_mask_o
    );
endinterface

// File: rtl/dcache_bank_gather_sel.sv
// Per-bank winner select: lowest pending lane targeting each bank wins (combinational, no state).
// Outputs the winner one-hot, its binary lane number (0 when no winner) and a bank-valid strobe.
module dcache_bank_gather_sel
    import dcache_bank_gather_pkg::*;
#(
    parameter int NBANK = DCACHE_BLOCKWORDS,
    parameter int NLANE = DCACHE_NLANES
) (
    input  logic [NLANE-1:0]                 pend_i,
    input  logic [$clog2(NBANK)*NLANE-1:0]   idx_i,
    output logic [NBANK*NLANE-1:0]           win_oh_o,
    output logic [$clog2(NLANE)*NBANK-1:0]   win_idx_o,
    output logic [NBANK-1:0]                 bank_vld_o
);
    localparam int LB = $clog2(NBANK);
    localparam int LL = $clog2(NLANE);

    function automatic logic [NBANK-1:0] bin2one(input logic [LB-1:0] b);
        logic [NBANK-1:0] oh;
        oh    = '0;
        oh[b] = 1'b1;
        return oh;
    endfunction

    function automatic logic [NLANE-1:0] fixed_pri_arb(input logic [NLANE-1:0] r);
        return r & (~r + NLANE'(1));
    endfunction

    function automatic logic [LL-1:0] one2bin(input logic [NLANE-1:0] oh);
        logic [LL-1:0] b;
        b = '0;
        for (int i = 0; i < NLANE; i++) begin
            if (oh[i]) b = b | LL'(i);
        end
        return b;
    endfunction

    logic [NBANK-1:0] lane_dec [NLANE];
    logic [NLANE-1:0] bank_req [NBANK];
    logic [NLANE-1:0] bank_gnt [NBANK];

    for (genvar i = 0; i < NLANE; i++) begin : g_dec
        assign lane_dec[i] = bin2one(idx_i[i*LB +: LB]);
    end

    for (genvar j = 0; j < NBANK; j++) begin : g_bank
        for (genvar i = 0; i < NLANE; i++) begin : g_lane
            assign bank_req[j][i] = pend_i[i] & lane_dec[i][j];
        end
        assign bank_gnt[j]                = fixed_pri_arb(bank_req[j]);
        assign win_oh_o[j*NLANE +: NLANE] = bank_gnt[j];
        assign win_idx_o[j*LL +: LL]      = one2bin(bank_gnt[j]);
        assign bank_vld_o[j]              = |bank_req[j];
    end
endmodule

// File: rtl/dcache_bank_gather.sv
// Serialises a multi-lane read over conflicting banks and gathers the returned words per lane.
// Response valid K+2 cycles after accept (K = worst bank sharing); holds until rsp_ready_i, one request in flight.
module dcache_bank_gather
    import dcache_bank_gather_pkg::*;
#(
    parameter int NBANK  = DCACHE_BLOCKWORDS,
    parameter int NLANE  = DCACHE_NLANES,
    parameter int WORD_W = DCACHE_WORD_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_bank_gather_if.slave  bus
);
    localparam int LB = $clog2(NBANK);
    localparam int LL = $clog2(NLANE);

    state_e                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    rsp_vld_q, rsp_vld_d;
    logic [NLANE-1:0]        pend_q, pend_d;
    logic [NLANE-1:0]        mask_q, mask_d;
    logic [NLANE-1:0]        sel_q, sel_d;
    logic [LB*NLANE-1:0]     idx_q, idx_d;
    logic [WORD_W*NLANE-1:0] data_q, data_d;

    logic [NLANE-1:0]        sel_pend;
    logic [NBANK*NLANE-1:0]  win_oh;
    logic [LL*NBANK-1:0]     win_idx;
    logic [NBANK-1:0]        bank_vld;
    logic [NLANE-1:0]        served;

    assign sel_pend = (state_q == ST_ISSUE) ? pend_q : '0;

    dcache_bank_gather_sel #(.NBANK(NBANK), .NLANE(NLANE)) u_sel (
        .pend_i     (sel_pend),
        .idx_i      (idx_q),
        .win_oh_o   (win_oh),
        .win_idx_o  (win_idx),
        .bank_vld_o (bank_vld)
    );

    always_comb begin
        served = '0;
        for (int j = 0; j < NBANK; j++) served = served | win_oh[j*NLANE +: NLANE];
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        mask_d  = mask_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sel_d   = '0;
        // Lanes granted last cycle pick up their word from the bank they addressed.
        for (int i = 0; i < NLANE; i++) begin
            if (sel_q[i]) begin
                data_d[i*WORD_W +: WORD_W] =
                    bus.bank_rd_data_i[int'(idx_q[i*LB +: LB])*WORD_W +: WORD_W];
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (ready_q && bus.req_valid_i) begin
                    mask_d  = bus.req_lane_mask_i;
                    idx_d   = bus.req_block_idx_i;
                    pend_d  = bus.req_lane_mask_i;
                    data_d  = '0;
                    state_d = (bus.req_lane_mask_i != '0) ? ST_ISSUE : ST_RSP;
                end
            end
            ST_ISSUE: begin
                pend_d = pend_q & ~served;
                sel_d  = served;
                if (pend_d == '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = ST_RSP;
            ST_RSP:   if (bus.rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        ready_d   = (state_d == ST_IDLE);
        rsp_vld_d = (state_d == ST_RSP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            rsp_vld_q <= 1'b0;
            pend_q    <= '0;
            mask_q    <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rsp_vld_q <= rsp_vld_d;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
        end
    end

    assign bus.req_ready_o     = ready_q;
    assign bus.bank_rd_en_o    = bank_vld;
    assign bus.bank_lane_idx_o = win_idx;
    assign bus.rsp_valid_o     = rsp_vld_q;
    assign bus.rsp_data_o      = data_q;
    assign bus.rsp_mask_o      = mask_q;
endmodule

// File: tb/tb_dcache_bank_gather.sv
// Randomised plus directed bench for dcache_bank_gather (4 banks, 4 lanes, 32-bit words).
// A lane-rank model predicts strobes, latency and gathered data every cycle.
module tb_dcache_bank_gather;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   live;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) live <= 1'b0;
        else        live <= 1'b1;
    end

    dcache_bank_gather_if #(.NBANK(4), .NLANE(4), .WORD_W(32)) bus ();

    dcache_bank_gather #(.NBANK(4), .NLANE(4), .WORD_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] pat(input int j, input int c);
        return 32'hB000_0000 | 32'(j) | (32'(c & 16'hFFFF) << 8);
    endfunction

    // Bank j presents a cycle-stamped word every cycle.
    always @(negedge clk) begin
        for (int j = 0; j < 4; j++) bus.bank_rd_data_i[j*32 +: 32] = pat(j, cyc);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm, input int limit);
        checks++;
        failures++;
        $display("FAIL timeout_%s waited=%0d cycles required<%0d t=%0t", nm, limit, limit, $time);
    endtask

    // Behavioural model: lane rank within its bank fixes its issue cycle and data stamp.
    bit         busy = 1'b0;
    int         p_m, k_m;
    logic [3:0] mask_m;
    int         idx_m [4];
    int         rank_m [4];

    always @(negedge clk) begin : cmp_proc
        logic [3:0]   e_en;
        logic [7:0]   e_li;
        logic [127:0] e_dat;
        bit           e_rv, e_rdy;
        int           rel;
        if (!rst_n) begin
            busy = 1'b0;
            chk("rst_ready", 128'(bus.req_ready_o), 128'd0);
            chk("rst_en", 128'(bus.bank_rd_en_o), 128'd0);
            chk("rst_lane_idx", 128'(bus.bank_lane_idx_o), 128'd0);
            chk("rst_rsp_valid", 128'(bus.rsp_valid_o), 128'd0);
            chk("rst_rsp_data", bus.rsp_data_o, 128'd0);
            chk("rst_rsp_mask", 128'(bus.rsp_mask_o), 128'd0);
        end else begin
            e_en = '0; e_li = '0; e_dat = '0; e_rv = 1'b0;
            e_rdy = !busy && live;
            if (busy) begin
                rel  = cyc - p_m + 1;
                e_rv = (k_m == 0) ? (rel >= 1) : (rel >= k_m + 2);
                for (int i = 0; i < 4; i++) begin
                    if (mask_m[i] && rank_m[i] == rel - 1) begin
                        e_en[idx_m[i]]          = 1'b1;
                        e_li[idx_m[i]*2 +: 2]   = 2'(i);
                    end
                    if (mask_m[i]) e_dat[i*32 +: 32] = pat(idx_m[i], p_m + rank_m[i] + 1);
                end
            end
            chk("m_bank_en", 128'(bus.bank_rd_en_o), 128'(e_en));
            chk("m_lane_idx", 128'(bus.bank_lane_idx_o), 128'(e_li));
            chk("m_rsp_valid", 128'(bus.rsp_valid_o), 128'(e_rv));
            chk("m_req_ready", 128'(bus.req_ready_o), 128'(e_rdy));
            if (e_rv) begin
                chk("m_rsp_data", bus.rsp_data_o, e_dat);
                chk("m_rsp_mask", 128'(bus.rsp_mask_o), 128'(mask_m));
            end
            if (busy && e_rv && bus.rsp_ready_i) begin
                busy = 1'b0;
            end else if (e_rdy && bus.req_valid_i) begin
                busy   = 1'b1;
                p_m    = cyc + 1;
                mask_m = bus.req_lane_mask_i;
                k_m    = 0;
                for (int i = 0; i < 4; i++) idx_m[i] = int'(bus.req_block_idx_i[i*2 +: 2]);
                for (int i = 0; i < 4; i++) begin
                    rank_m[i] = 0;
                    for (int l = 0; l < i; l++)
                        if (mask_m[l] && idx_m[l] == idx_m[i]) rank_m[i]++;
                    if (mask_m[i] && rank_m[i] + 1 > k_m) k_m = rank_m[i] + 1;
                end
            end
        end
    end

    logic [3:0]   rec_en [64];
    logic [7:0]   rec_li [64];
    logic [127:0] rec_dat;
    logic [3:0]   rec_mask;

    task automatic run_txn(input logic [3:0] m, input logic [7:0] ix, input int bp,
                           output int lat, output int p);
        int rel;
        lat = -1;
        p   = -1;
        for (int r = 0; r < 64; r++) begin rec_en[r] = '0; rec_li[r] = '0; end
        @(posedge clk); #2;
        bus.req_valid_i = 1'b1; bus.req_lane_mask_i = m; bus.req_block_idx_i = ix;
        for (int t = 0; t < 20 && p < 0; t++) begin
            @(negedge clk);
            if (bus.req_ready_o) p = cyc + 1;
        end
        if (p < 0) begin
            tmo("accept", 20);
            @(posedge clk); #2; bus.req_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #2;
        bus.req_valid_i     = 1'($urandom_range(0, 1));
        bus.req_lane_mask_i = 4'($urandom);
        bus.req_block_idx_i = 8'($urandom);
        for (int t = 0; t < 20 && lat < 0; t++) begin
            if (t > 0) @(negedge clk);
            else       @(negedge clk);
            rel = cyc - p + 1;
            if (rel >= 0 && rel < 64) begin
                rec_en[rel] = bus.bank_rd_en_o;
                rec_li[rel] = bus.bank_lane_idx_o;
            end
            if (bus.rsp_valid_o) begin
                lat = rel; rec_dat = bus.rsp_data_o; rec_mask = bus.rsp_mask_o;
            end
        end
        @(posedge clk); #2; bus.req_valid_i = 1'b0;
        if (lat < 0) begin tmo("rsp", 20); return; end
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 128'(bus.rsp_valid_o), 128'd1);
            chk("bp_req_ready", 128'(bus.req_ready_o), 128'd0);
            @(posedge clk); #2;
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #2; bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", 128'(bus.req_ready_o), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog elapsed=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, p, acc;
        rst_n = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_lane_mask_i = '0; bus.req_block_idx_i = '0;
        bus.rsp_ready_i = 1'b0; bus.bank_rd_data_i = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: no conflict
        run_txn(4'hF, 8'hE4, 0, lat, p);
        chk("s1_lat", 128'(lat), 128'd3);
        chk("s1_en1", 128'(rec_en[1]), 128'hF);
        chk("s1_li1", 128'(rec_li[1]), 128'hE4);
        chk("s1_en2", 128'(rec_en[2]), 128'h0);
        for (int i = 0; i < 4; i++)
            chk("s1_data", 128'(rec_dat[i*32 +: 32]), 128'(32'hB000_0000 + 32'(i) + 32'((p + 1) << 8)));

        // 2: full conflict on bank 2
        run_txn(4'hF, 8'hAA, 0, lat, p);
        chk("s2_lat", 128'(lat), 128'd6);
        for (int k = 1; k <= 4; k++) begin
            chk("s2_en", 128'(rec_en[k]), 128'h4);
            chk("s2_li", 128'(rec_li[k]), 128'((k - 1) << 4));
        end
        chk("s2_en5", 128'(rec_en[5]), 128'h0);
        for (int i = 0; i < 4; i++)
            chk("s2_data", 128'(rec_dat[i*32 +: 32]), 128'(32'hB000_0002 + 32'((p + i + 1) << 8)));

        // 3: partial mask, lane 2 inactive
        run_txn(4'b1011, 8'h74, 0, lat, p);
        chk("s3_lat", 128'(lat), 128'd4);
        chk("s3_en1", 128'(rec_en[1]), 128'h3);
        chk("s3_li1", 128'(rec_li[1]), 128'h04);
        chk("s3_en2", 128'(rec_en[2]), 128'h2);
        chk("s3_li2", 128'(rec_li[2]), 128'h0C);
        chk("s3_mask", 128'(rec_mask), 128'hB);
        chk("s3_lane0", 128'(rec_dat[31:0]), 128'(32'hB000_0000 + 32'((p + 1) << 8)));
        chk("s3_lane1", 128'(rec_dat[63:32]), 128'(32'hB000_0001 + 32'((p + 1) << 8)));
        chk("s3_lane2", 128'(rec_dat[95:64]), 128'd0);
        chk("s3_lane3", 128'(rec_dat[127:96]), 128'(32'hB000_0001 + 32'((p + 2) << 8)));

        // 4: response backpressure
        run_txn(4'hF, 8'h1B, 5, lat, p);
        chk("s4_lat", 128'(lat), 128'd3);

        // 5: zero mask
        run_txn(4'h0, 8'h5A, 0, lat, p);
        chk("s5_lat", 128'(lat), 128'd1);
        chk("s5_en1", 128'(rec_en[1]), 128'h0);
        chk("s5_mask", 128'(rec_mask), 128'h0);
        chk("s5_data", rec_dat, 128'd0);

        // 6: reset during the conflict sequence, then a clean request
        @(posedge clk); #2;
        bus.req_valid_i = 1'b1; bus.req_lane_mask_i = 4'hF; bus.req_block_idx_i = 8'hAA;
        acc = 0;
        for (int t = 0; t < 20 && acc == 0; t++) begin
            @(negedge clk);
            if (bus.req_ready_o) acc = 1;
        end
        if (acc == 0) tmo("s6_accept", 20);
        @(posedge clk); #2; bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("s6_en_before_rst", 128'(bus.bank_rd_en_o), 128'h4);
        @(posedge clk); #2; rst_n = 1'b0;
        #1;
        chk("s6_en_rst", 128'(bus.bank_rd_en_o), 128'h0);
        chk("s6_li_rst", 128'(bus.bank_lane_idx_o), 128'h0);
        chk("s6_ready_rst", 128'(bus.req_ready_o), 128'h0);
        chk("s6_data_rst", bus.rsp_data_o, 128'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_txn(4'hF, 8'hE4, 0, lat, p);
        chk("s6_lat", 128'(lat), 128'd3);
        for (int i = 0; i < 4; i++)
            chk("s6_data", 128'(rec_dat[i*32 +: 32]), 128'(32'hB000_0000 + 32'(i) + 32'((p + 1) << 8)));

        // Random traffic against the model
        for (int n = 0; n < 40; n++) begin
            logic [3:0] rm;
            rm = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            run_txn(rm, 8'($urandom), int'($urandom_range(0, 3)), lat, p);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
